// File: rtl/hilo_multiplier.sv
// rtl/hilo_multiplier.sv - multi-cycle unsigned shift-add multiplier committing HI/LO
module hilo_multiplier #(
   parameter logic [5:0] MULTU = 6'b011001,
   parameter int         WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic [5:0]       Signal,
   input  logic             start,
   output logic [WIDTH-1:0] HiOut,
   output logic [WIDTH-1:0] LoOut,
   output logic             busy,
   output logic             done
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t             state;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_next;
   logic [CW-1:0]      count;
   logic [WIDTH:0]     sum;
   logic               accept;

   assign accept = start && (Signal == MULTU);

   // The extra sum bit carries into the shifted upper half, so no carry is lost.
   always_comb begin
      sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
      if (prod[0]) begin
         sum = sum + {1'b0, mcand};
      end
      prod_next = {sum, prod[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         mcand <= '0;
         prod  <= '0;
         count <= '0;
         HiOut <= '0;
         LoOut <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (accept) begin
                  mcand <= dataA;
                  prod  <= {{WIDTH{1'b0}}, dataB};
                  count <= '0;
                  busy  <= 1'b1;
                  state <= MUL;
               end
            end
            MUL: begin
               prod  <= prod_next;
               count <= count + CW'(1);
               // HI/LO only change here, so readers never see a partial product.
               if (count == LAST) begin
                  HiOut <= prod_next[2*WIDTH-1:WIDTH];
                  LoOut <= prod_next[WIDTH-1:0];
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
